// File: rtl/main_memory_responder.sv
// main_memory_responder
//   Word-addressed 32K x 16 main memory model with a fixed-latency read
//   pipeline and periodic refresh windows that freeze the responder.
//
// Ports
//   clk                 single clock, all state updates on the rising edge
//   rst_n               asynchronous active-low reset
//   memory_request      request strobe, sampled each rising edge
//   memory_write        1 = write, 0 = read (qualified by memory_request)
//   memory_address[15:0] byte address, word index = bits 15:1
//   memory_data_in[15:0] write data
//   memory_data_out[15:0] read data, forced to 0 when memory_data_valid = 0
//   memory_data_valid   one-cycle pulse per returned read
//   memory_stall        refresh in progress (registered); requests dropped
`timescale 1ns/1ps

module main_memory_responder #(
  parameter int LATENCY        = 4,
  parameter int REFRESH_PERIOD = 256,
  parameter int REFRESH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memory_request,
  input  logic        memory_write,
  input  logic [15:0] memory_address,
  input  logic [15:0] memory_data_in,
  output logic [15:0] memory_data_out,
  output logic        memory_data_valid,
  output logic        memory_stall
);

  localparam int CW = ($clog2(REFRESH_PERIOD) > 8) ? $clog2(REFRESH_PERIOD) : 8;
  localparam int SW = $clog2(REFRESH_CYCLES) + 1;

  logic [15:0]   mem [32768];
  logic [15:0]   rd_data;
  logic [14:0]   word_index;
  logic          accept_read;
  logic          accept_write;
  logic          addr_lsb_unused;

  logic [LATENCY-1:0] pipe_valid;
  logic [15:0]        pipe_data [1:LATENCY-1];

  logic [CW-1:0] refresh_cnt;
  logic [SW-1:0] stall_cnt;

  assign word_index      = memory_address[15:1];
  assign addr_lsb_unused = memory_address[0];

  // memory_stall is the registered value from the previous edge, so this
  // is exactly "request high and not stalled in the preceding cycle".
  assign accept_write = memory_request &  memory_write & ~memory_stall;
  assign accept_read  = memory_request & ~memory_write & ~memory_stall;

  // Block RAM with registered read. rd_data is pipeline stage 0's data; it
  // only loads on an accepted read, so it also holds through a stall. A read
  // one cycle after a write to the same word sees the new word because the
  // write landed at the earlier edge.
  always_ff @(posedge clk) begin
    if (accept_write) begin
      mem[word_index] <= memory_data_in;
    end
    if (accept_read) begin
      rd_data <= mem[word_index];
    end
  end

  // Read return pipeline: stage 0 valid pairs with rd_data, stages
  // 1..LATENCY-1 carry their own data. The whole pipe freezes during refresh,
  // which delays every in-flight read by exactly REFRESH_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else if (!memory_stall) begin
      pipe_valid   <= {pipe_valid[LATENCY-2:0], accept_read};
      pipe_data[1] <= rd_data;
      for (int i = 2; i < LATENCY; i++) begin
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  // Refresh scheduler: count non-stall cycles, then hold memory_stall for
  // REFRESH_CYCLES cycles with the period counter parked at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt  <= '0;
      stall_cnt    <= '0;
      memory_stall <= 1'b0;
    end else if (!memory_stall) begin
      if (refresh_cnt == CW'(REFRESH_PERIOD - 1)) begin
        refresh_cnt  <= '0;
        stall_cnt    <= '0;
        memory_stall <= 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end else begin
      if (stall_cnt == SW'(REFRESH_CYCLES - 1)) begin
        memory_stall <= 1'b0;
      end
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // A read sitting in the last stage when refresh starts is masked, held,
  // and presented once the stall ends, so it is deferred rather than lost.
  always_comb begin
    memory_data_valid = pipe_valid[LATENCY-1] & ~memory_stall;
    memory_data_out   = memory_data_valid ? pipe_data[LATENCY-1] : 16'h0000;
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder
//   Directed-vector bench. Two responders share stimulus: dut_a uses the
//   default parameters, dut_b uses REFRESH_PERIOD=16 so refresh behaviour
//   can be exercised in a short run. Expected values are hand-written per
//   cycle, where cycle 0 is the first cycle after reset release.
`timescale 1ns/1ps

module tb_main_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memory_request;
  logic        memory_write;
  logic [15:0] memory_address;
  logic [15:0] memory_data_in;

  logic [15:0] a_data_out, b_data_out;
  logic        a_data_valid, b_data_valid;
  logic        a_stall, b_stall;

  int vec_count = 0;
  int err_count = 0;

  logic        v_req  [64];
  logic        v_wr   [64];
  logic [15:0] v_addr [64];
  logic [15:0] v_din  [64];
  logic        v_ev   [64];
  logic [15:0] v_ed   [64];
  logic        v_es   [64];

  always #5 clk = ~clk;

  main_memory_responder dut_a (
    .clk               (clk),
    .rst_n             (rst_n),
    .memory_request    (memory_request),
    .memory_write      (memory_write),
    .memory_address    (memory_address),
    .memory_data_in    (memory_data_in),
    .memory_data_out   (a_data_out),
    .memory_data_valid (a_data_valid),
    .memory_stall      (a_stall)
  );

  main_memory_responder #(
    .LATENCY        (4),
    .REFRESH_PERIOD (16),
    .REFRESH_CYCLES (2)
  ) dut_b (
    .clk               (clk),
    .rst_n             (rst_n),
    .memory_request    (memory_request),
    .memory_write      (memory_write),
    .memory_address    (memory_address),
    .memory_data_in    (memory_data_in),
    .memory_data_out   (b_data_out),
    .memory_data_valid (b_data_valid),
    .memory_stall      (b_stall)
  );

  task automatic check_eq(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      err_count++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    memory_request = 1'b0;
    memory_write   = 1'b0;
    memory_address = '0;
    memory_data_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic clear_vectors();
    for (int i = 0; i < 64; i++) begin
      v_req[i]  = 1'b0;
      v_wr[i]   = 1'b0;
      v_addr[i] = '0;
      v_din[i]  = '0;
      v_ev[i]   = 1'b0;
      v_ed[i]   = '0;
      v_es[i]   = 1'b0;
    end
  endtask

  task automatic set_wr(input int k, input logic [15:0] addr, input logic [15:0] data);
    v_req[k]  = 1'b1;
    v_wr[k]   = 1'b1;
    v_addr[k] = addr;
    v_din[k]  = data;
  endtask

  task automatic set_rd(input int k, input logic [15:0] addr);
    v_req[k]  = 1'b1;
    v_wr[k]   = 1'b0;
    v_addr[k] = addr;
  endtask

  task automatic set_exp(input int k, input logic [15:0] data);
    v_ev[k] = 1'b1;
    v_ed[k] = data;
  endtask

  // Each cycle: check the selected DUT's outputs, then drive this cycle's inputs.
  task automatic run_vectors(input string name, input int n, input bit on_b);
    for (int k = 0; k < n; k++) begin
      logic        valid_obs;
      logic [15:0] data_obs;
      logic        stall_obs;
      valid_obs = on_b ? b_data_valid : a_data_valid;
      data_obs  = on_b ? b_data_out   : a_data_out;
      stall_obs = on_b ? b_stall      : a_stall;
      check_eq($sformatf("%s c%0d valid", name, k), {31'd0, valid_obs}, {31'd0, v_ev[k]});
      check_eq($sformatf("%s c%0d data", name, k), {16'd0, data_obs}, {16'd0, v_ed[k]});
      check_eq($sformatf("%s c%0d stall", name, k), {31'd0, stall_obs}, {31'd0, v_es[k]});
      memory_request = v_req[k];
      memory_write   = v_wr[k];
      memory_address = v_addr[k];
      memory_data_in = v_din[k];
      if (v_req[k] || v_wr[k]) begin
        $display("%s cycle %0d: req=%0b wr=%0b addr=%h din=%h", name, k,
                 v_req[k], v_wr[k], v_addr[k], v_din[k]);
      end
      tick();
    end
    memory_request = 1'b0;
    memory_write   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    memory_request = 1'b0;
    memory_write   = 1'b0;
    memory_address = '0;
    memory_data_in = '0;
    tick();
    tick();
    check_eq("reset a valid", {31'd0, a_data_valid}, 32'd0);
    check_eq("reset a data", {16'd0, a_data_out}, 32'd0);
    check_eq("reset a stall", {31'd0, a_stall}, 32'd0);
    check_eq("reset b valid", {31'd0, b_data_valid}, 32'd0);
    check_eq("reset b stall", {31'd0, b_stall}, 32'd0);
    rst_n = 1'b1;

    // Write BEEF, read it next cycle (returns at c+4), then the odd byte
    // address of the same word one cycle later.
    clear_vectors();
    set_wr(0, 16'h0040, 16'hBEEF);
    set_rd(1, 16'h0040);
    set_rd(2, 16'h0041);
    set_exp(5, 16'hBEEF);
    set_exp(6, 16'hBEEF);
    run_vectors("raw", 9, 1'b0);

    // Preload data = address, then eight back-to-back reads.
    do_reset();
    clear_vectors();
    for (int i = 0; i < 8; i++) begin
      set_wr(i, 16'h0100 + 16'(2 * i), 16'h0100 + 16'(2 * i));
      set_rd(8 + i, 16'h0100 + 16'(2 * i));
      set_exp(12 + i, 16'h0100 + 16'(2 * i));
    end
    run_vectors("burst", 22, 1'b0);

    // memory_write without memory_request must not modify the word.
    do_reset();
    clear_vectors();
    set_wr(0, 16'h0300, 16'hA5A5);
    v_wr[1]   = 1'b1;
    v_addr[1] = 16'h0300;
    v_din[1]  = 16'h5A5A;
    set_rd(2, 16'h0300);
    set_exp(6, 16'hA5A5);
    run_vectors("nowr", 8, 1'b0);

    // Refresh on dut_b: onset at cycle 16, two stall cycles. Read at 14
    // returns at 20; write/read during stall are dropped; read at 18 -> 22.
    do_reset();
    clear_vectors();
    set_wr(0, 16'h0200, 16'h1234);
    set_rd(14, 16'h0200);
    set_wr(16, 16'h0200, 16'h5555);
    set_rd(17, 16'h0200);
    set_rd(18, 16'h0200);
    v_es[16] = 1'b1;
    v_es[17] = 1'b1;
    set_exp(20, 16'h1234);
    set_exp(22, 16'h1234);
    run_vectors("refresh", 24, 1'b1);

    // Three reads in flight, reset pulsed in the middle of the first return.
    do_reset();
    clear_vectors();
    set_rd(0, 16'h0100);
    set_rd(1, 16'h0102);
    set_rd(2, 16'h0104);
    run_vectors("flight", 4, 1'b0);
    check_eq("flight c4 valid", {31'd0, a_data_valid}, 32'd1);
    check_eq("flight c4 data", {16'd0, a_data_out}, 32'h0100);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midreset a valid", {31'd0, a_data_valid}, 32'd0);
    check_eq("midreset a data", {16'd0, a_data_out}, 32'd0);
    check_eq("midreset b valid", {31'd0, b_data_valid}, 32'd0);
    check_eq("midreset b data", {16'd0, b_data_out}, 32'd0);
    check_eq("midreset b stall", {31'd0, b_stall}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_vectors();
    v_es[16] = 1'b1;
    v_es[17] = 1'b1;
    run_vectors("postreset", 20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/main_memory_responder.md
MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

Interface
REQ-001 Parameter LATENCY, default 4, cycles from accepted read request to data return (legal 2..8).
REQ-002 Parameter REFRESH_PERIOD, default 256, cycles between refresh windows.
REQ-003 Parameter REFRESH_CYCLES, default 2, length of each refresh window in cycles.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 memory_request  input  1  request strobe, sampled each rising edge.
REQ-007 memory_write  input  1  1 = write, 0 = read; qualified by memory_request.
REQ-008 memory_address  input  16  byte address; bit 0 ignored (word index = bits 15:1).
REQ-009 memory_data_in  input  16  write data.
REQ-010 memory_data_out  output  16  read data; valid only with memory_data_valid.
REQ-011 memory_data_valid  output  1  one-cycle pulse per returned read.
REQ-012 memory_stall  output  1  refresh in progress; requests not accepted, pipeline frozen.

Function
REQ-013 Storage: 32768 x 16-bit words, indexed by memory_address[15:1].
REQ-014 Accept: a request is accepted at a rising edge iff memory_request=1 and memory_stall=0 in the preceding cycle.
REQ-015 memory_write=1 with memory_request=0 shall have no effect.
REQ-016 Accepted write: word written at the accepting edge; no response, memory_data_valid never asserted for it.
REQ-017 Accepted read: array sampled at the accepting edge; the sampled word is carried through a LATENCY-deep shift pipeline (valid bit + 16-bit data per stage).
REQ-018 Read-after-write: a read accepted in the cycle after a write to the same word returns the new data; a read and write cannot be accepted in the same cycle.
REQ-019 Latency: read request high in cycle c (no stall) -> memory_data_valid=1 and memory_data_out=data in cycle c+LATENCY, for exactly one cycle.
REQ-020 Throughput: one read accepted per cycle; back-to-back reads return back-to-back, in request order.
REQ-021 memory_data_out shall be 16'h0000 whenever memory_data_valid=0.
REQ-022 Refresh counter: 8+ bit counter, increments every non-stall cycle; on reaching REFRESH_PERIOD-1 it clears to 0 and memory_stall rises for the next REFRESH_CYCLES cycles.
REQ-023 memory_stall is driven directly from a register (no combinational path from inputs).
REQ-024 During stall: requests dropped (not queued, writes not performed), pipeline frozen (contents held), memory_data_valid=0, refresh counter held at 0.
REQ-025 After stall: pipeline resumes; each in-flight read returns exactly REFRESH_CYCLES cycles later than REQ-019 timing; no read lost or duplicated.
REQ-026 A read whose return cycle coincides with stall onset is deferred, not dropped.
REQ-027 Requester protocol: requester holds request/address while memory_stall=1 and re-presents them; responder keeps no retry state.

Reset
REQ-028 rst_n=0 asynchronously clears: all pipeline valid bits, pipeline data, refresh counter, memory_stall=0, memory_data_valid=0, memory_data_out=16'h0000.
REQ-029 Array contents are not reset; reads of never-written words return undefined data.
REQ-030 Reset mid-operation discards all in-flight reads; no memory_data_valid pulse for them after release.
REQ-031 First rising edge after rst_n deassertion may accept a request; refresh counter starts from 0, so the first stall begins after REFRESH_PERIOD cycles.

Verification
REQ-032 Write 16'hBEEF to 16'h0040, read 16'h0040 next cycle at cycle c -> valid=1, data_out=16'hBEEF in cycle c+4 only.
REQ-033 Eight reads back-to-back, 16'h0100..16'h010E step 2 (preloaded data = address) -> eight consecutive valid cycles, data in order, data_out=0 before and after.
REQ-034 Read issued 2 cycles before refresh onset (REFRESH_PERIOD=16, REFRESH_CYCLES=2) -> stall high 2 cycles, request during stall ignored, data returned at c+6.
REQ-035 Odd address 16'h0041 read after write to 16'h0040 -> same word returned.
REQ-036 Three reads in flight, rst_n pulsed low mid-cycle -> outputs immediately 0, no valid pulse afterwards, stall=0, next refresh REFRESH_PERIOD cycles after release.
REQ-037 Write with memory_request=0, then read same word -> old contents returned.
